// File: rtl/adder94_rr_arbiter.sv
// Round-robin arbiter in front of a two-stage 94-bit adder (47-bit halves, carry pipelined).
// Compensates for b_high being sampled one cycle after b_low and returns a tagged, registered sum.
module adder94_rr_arbiter #(
    parameter int HALF = 47
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [2*HALF-1:0]   req0_a,
    input  logic [2*HALF-1:0]   req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [2*HALF-1:0]   req1_a,
    input  logic [2*HALF-1:0]   req1_b,
    output logic                req1_ready,
    input  logic                stall,
    output logic                res_valid,
    output logic [2*HALF-1:0]   res,
    output logic                res_tag,
    output logic                busy
);
    localparam int W = 2 * HALF;

    // Handshake: a requester's operands transfer in any cycle where its valid and ready are both high.
    logic            ptr;
    logic            grant;
    logic            gidx;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    adder_a;
    logic [W-1:0]    adder_b;
    logic [HALF:0]   low_sum;
    logic [HALF-1:0] c_high;

    logic [HALF-1:0] bh_skew;
    logic [HALF-1:0] a_hi_r;
    logic            carry_r;
    logic [HALF-1:0] low_r;
    logic            v1;
    logic            tag1;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && !stall) begin
            req0_ready = req0_valid && (!req1_valid || !ptr);
            req1_ready = req1_valid && (!req0_valid || ptr);
        end
    end

    assign grant = req0_ready | req1_ready;
    assign gidx  = req1_ready;
    assign sel_a = gidx ? req1_a : req0_a;
    assign sel_b = gidx ? req1_b : req0_b;

    // The adder's b_high port is fed from the skew register, i.e. the previous issue's high half.
    assign adder_a = grant ? sel_a : '0;
    assign adder_b = {bh_skew, (grant ? sel_b[HALF-1:0] : {HALF{1'b0}})};

    assign low_sum = {1'b0, adder_a[HALF-1:0]} + {1'b0, adder_b[HALF-1:0]};
    assign c_high  = a_hi_r + adder_b[W-1:HALF] + {{(HALF-1){1'b0}}, carry_r};

    assign busy = v1 | res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            bh_skew   <= '0;
            a_hi_r    <= '0;
            carry_r   <= 1'b0;
            low_r     <= '0;
            v1        <= 1'b0;
            tag1      <= 1'b0;
            res_valid <= 1'b0;
            res       <= '0;
            res_tag   <= 1'b0;
        end else begin
            if (grant) begin
                ptr <= ~gidx;
            end
            bh_skew   <= grant ? sel_b[W-1:HALF] : {HALF{1'b0}};
            a_hi_r    <= adder_a[W-1:HALF];
            carry_r   <= low_sum[HALF];
            low_r     <= low_sum[HALF-1:0];
            v1        <= grant;
            tag1      <= gidx;
            res_valid <= v1;
            if (v1) begin
                res     <= {c_high, low_r};
                res_tag <= tag1;
            end
        end
    end
endmodule

// File: tb/tb_adder94_rr_arbiter.sv
// Bench for adder94_rr_arbiter: directed plan steps plus random traffic against a
// queue-based reference (full-width modular sums, due-cycle scheduling).
module tb_adder94_rr_arbiter;
    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [93:0] req0_a;
    logic [93:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [93:0] req1_a;
    logic [93:0] req1_b;
    logic        req1_ready;
    logic        stall;
    logic        res_valid;
    logic [93:0] res;
    logic        res_tag;
    logic        busy;

    adder94_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .stall      (stall),
        .res_valid  (res_valid),
        .res        (res),
        .res_tag    (res_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference state: arbitration pointer, in-flight ops with their due cycles, held output.
    logic        m_ptr = 1'b0;
    logic [94:0] exp_q[$];
    int          due_q[$];
    logic [93:0] held_res = '0;
    logic        held_tag = 1'b0;

    task automatic chk(input string tag, input logic [93:0] obs, input logic [93:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        g_any;
        logic        g;
        logic        exp_v;
        logic        exp_v1;
        logic [93:0] sum;
        @(negedge clk);
        g_any = 1'b0;
        g = 1'b0;
        if (!rst && !stall) begin
            if (req0_valid && req1_valid) begin
                g_any = 1'b1;
                g = m_ptr;
            end else if (req0_valid || req1_valid) begin
                g_any = 1'b1;
                g = req1_valid;
            end
        end
        chk("req0_ready", {93'd0, req0_ready}, {93'd0, g_any && !g});
        chk("req1_ready", {93'd0, req1_ready}, {93'd0, g_any && g});

        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        if (exp_v) begin
            {held_tag, held_res} = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        exp_v1 = (due_q.size() > 0) && (due_q[0] == cyc + 1);
        chk("res_valid", {93'd0, res_valid}, {93'd0, exp_v});
        chk("res", res, held_res);
        chk("res_tag", {93'd0, res_tag}, {93'd0, held_tag});
        chk("busy", {93'd0, busy}, {93'd0, exp_v || exp_v1});

        if (rst) begin
            exp_q.delete();
            due_q.delete();
            m_ptr = 1'b0;
            held_res = '0;
            held_tag = 1'b0;
        end else if (g_any) begin
            sum = g ? (req1_a + req1_b) : (req0_a + req0_b);
            exp_q.push_back({g, sum});
            due_q.push_back(cyc + 2);
            m_ptr = ~g;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v0, input logic [93:0] a0, input logic [93:0] b0,
                         input logic v1, input logic [93:0] a1, input logic [93:0] b1);
        req0_valid = v0;
        req0_a = a0;
        req0_b = b0;
        req1_valid = v1;
        req1_a = a1;
        req1_b = b1;
    endtask

    function automatic logic [93:0] rnd94();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return '1;
            1: return {47'd0, r[46:0]} | (94'd1 << 93);
            default: return r[93:0];
        endcase
    endfunction

    logic [93:0] p47;
    logic [93:0] p93;

    initial begin
        p47 = 94'd1 << 47;
        p93 = 94'd1 << 93;
        rst = 1'b1;
        stall = 1'b0;
        drive(0, '0, '0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;

        // Carry across halves
        drive(1, p47 - 94'd1, 94'd1, 0, '0, '0);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Back-to-back skew check from requester 1
        drive(0, '0, '0, 1, '0, p47 * 94'd5 + 94'd3);
        cycle();
        drive(0, '0, '0, 1, p47 * 94'd2, p47 * 94'd7);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Round-robin from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 94'(k), 94'(k), 1, 94'(100 + k), 94'(100 + k));
            cycle();
        end
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Wrap-around
        drive(1, p93, p93, 0, '0, '0);
        cycle();
        drive(1, '1, 94'd2, 0, '0, '0);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Stall and drain
        drive(1, 94'd11, 94'd22, 0, '0, '0);
        cycle();
        stall = 1'b1;
        drive(1, 94'd5, 94'd6, 1, 94'd7, 94'd8);
        repeat (3) cycle();
        stall = 1'b0;
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Reset mid-flight
        drive(0, '0, '0, 1, 94'd9, 94'd9);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        drive(1, 94'd1, 94'd2, 1, 94'd3, 94'd4);
        cycle();
        drive(0, '0, '0, 0, '0, '0);
        repeat (3) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, rnd94(), rnd94(),
                  $urandom_range(0, 3) != 0, rnd94(), rnd94());
            stall = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;
        stall = 1'b0;
        drive(0, '0, '0, 0, '0, '0);
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder94_rr_arbiter.md
Name: adder94_rr_arbiter

Overview:
- Shares one pipelined 94-bit adder (adder_94bit, two 47-bit halves, one-cycle carry pipeline) between two requesters in the lift_shoup datapath.
- Arbitrates round-robin and corrects the adder's operand skew: the high half of operand b is sampled one cycle after the low half.
- Aligns both result halves and returns a registered 94-bit sum tagged with the issuing requester.
- Sustains one issue per cycle.

Parameters:
- HALF, 47, width of each adder half; full operand width is 2*HALF = 94; only the default is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  94  requester 0 operand a.
- req0_b  in  94  requester 0 operand b.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_a  in  94  requester 1 operand a.
- req1_b  in  94  requester 1 operand b.
- req1_ready  out  1  requester 1 operands accepted this cycle.
- stall  in  1  blocks new issue; in-flight operations drain.
- res_valid  out  1  res and res_tag valid.
- res  out  94  (a+b) mod 2^94.
- res_tag  out  1  requester index of res.
- busy  out  1  an operation is in flight or res_valid is high.

Behaviour:
- Handshake: a transfer occurs in cycle t when reqN_valid and reqN_ready are both high. reqN_ready is combinational from valids, ptr, stall and rst. Requester operands need only be valid in cycle t.
- Arbitration, state ptr (1 bit):
  - Neither valid: no grant; ptr unchanged.
  - One valid: grant it.
  - Both valid: grant req[ptr].
  - After any grant: ptr <= ~granted index.
  - stall=1 or rst=1: both readies 0; ptr unchanged.
- Issue at cycle t, granted index g:
  - Adder a input = req_g_a, driven combinationally in cycle t.
  - Adder b input = {bh_skew, req_g_b[46:0]}.
  - bh_skew register <= req_g_b[93:47] at end of t, so the adder sees the correct b_high in t+1.
  - With no issue in t, adder a/b inputs are 0 and bh_skew is loaded with 0 at end of t, so the adder sees 0 as b_high in t+1.
- Pipeline:
  - End of t: low_r <= c_low; v1 <= grant; tag1 <= g.
  - End of t+1: res <= {c_high, low_r}; res_valid <= v1; res_tag <= tag1.
  - Latency: res_valid is high in cycle t+2. Throughput: 1 per cycle. No output backpressure; the consumer must accept every res_valid beat.
- res, res_tag hold their previous values when res_valid=0 and only update on a valid beat.
- Arithmetic: carry out of the low half propagates into the high half; carry out of bit 93 is discarded (modular 2^94).
- busy = v1 | res_valid.
- Reset (synchronous): res_valid=0, res=0, res_tag=0, ptr=0, bh_skew=0, low_r=0, v1=0, tag1=0, busy=0.
  - rst asserted mid-operation discards all in-flight ops: res_valid=0 in the cycle after rst is sampled.
  - No grant occurs while rst=1.
- stall asserted with ops in flight: they complete on schedule. stall deasserts: issue resumes the same cycle.
- Simultaneous requests every cycle: grants strictly alternate 0,1,0,1 starting from ptr.

Test Plan:
- Carry across halves: req0 a=2^47-1, b=1 issued at t -> res_valid at t+2; res=2^47 (0x8000_0000_0000); res_tag=0.
- Skew correctness, back-to-back issue from req1:
  - t: a=0, b=2^47·5+3 -> res at t+2 = 2^47·5+3.
  - t+1: a=2^47·2, b=2^47·7 -> res at t+3 = 2^47·9.
  - Any leakage of b_high between consecutive ops produces a wrong value.
- Round-robin: both valid continuously for 6 cycles after reset -> ready pattern req0,req1,req0,req1,req0,req1. Result tags 0,1,0,1,0,1 arrive with 2-cycle latency and distinct sums (req0 a=b=k, req1 a=b=100+k per cycle k).
- Wrap-around: a=2^93, b=2^93 -> res=0. Then a=2^94-1, b=2 -> res=1.
- Stall and drain: issue one op, assert stall next cycle for 3 cycles with both valid -> the issued op's result appears at t+2; no readies during stall; busy falls after the drain; the first grant after stall goes to the ptr requester.
- Reset mid-flight: issue at t, rst=1 at t+1 -> res_valid stays 0 at t+2; ptr=0; next grant with both valid goes to req0.
